systolic_feed_ctrl: RTL and testbench
=====================================

Name: systolic_feed_ctrl

Overview:
- Sequencer for the MEM_FIFO block: starts the memory-to-FIFO load, waits for load completion, then issues diagonally skewed read enables to the five lane FIFOs.
- The skew makes operands enter the systolic array as a wavefront.
- Sits between the top-level control and MEM_FIFO; drives init, base_address and rd_en, and consumes com.

Parameters:
- LANES, 5, number of FIFO lanes / array rows; width of rd_en.
- DEPTH, 5, words read per lane per run.
- ADDR_W, 8, base address width.
- LOAD_TIMEOUT, 255, max cycles in LOAD waiting for com before error.

Ports:
- clk  input  1  clock; rising edge.
- rst  input  1  synchronous active-low reset (rst=0 resets on the next clk edge).
- start  input  1  single-cycle request to begin a run; sampled only in IDLE.
- base_in  input  ADDR_W  base address for the run; captured with start.
- com  input  1  load-complete from MEM_FIFO; level, sampled in LOAD only.
- init  output  1  load enable to MEM_FIFO.
- base_address  output  ADDR_W  registered base address to MEM_FIFO.
- rd_en  output  LANES  per-lane FIFO read enables.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at normal completion.
- err  output  1  sticky load-timeout flag; cleared by reset or the next accepted start.

Behaviour:
- Reset (rst=0 at edge): state=IDLE, init=0, base_address=0, rd_en=0, busy=0, done=0, err=0, counters=0.
  - Reset mid-run aborts immediately; no done pulse.
- States: IDLE, LOAD, STREAM, FINISH. All outputs are registered.
- IDLE:
  - If start=1: latch base_in into base_address, clear err, clear cycle counter, go to LOAD.
  - init, busy and rd_en assert from the cycle after the start edge.
  - start in any other state is ignored.
- LOAD:
  - init=1 and the cycle counter increments each cycle.
  - If com=1: init=0 next cycle, counter cleared, go to STREAM.
  - Otherwise, if the counter reaches LOAD_TIMEOUT: err=1, init=0, go to IDLE with no done pulse.
  - If com and timeout occur in the same cycle, com wins.
- STREAM:
  - Step counter t runs from 0 to DEPTH+LANES-2.
  - rd_en[i]=1 exactly when i <= t < i+DEPTH. Lane 0 starts first; each lane starts one cycle after the previous one.
  - Each lane is high for exactly DEPTH consecutive cycles.
  - Total STREAM length is DEPTH+LANES-1 cycles (9 for defaults).
  - After t=DEPTH+LANES-2, go to FINISH; rd_en=0 on that transition.
- FINISH: done=1 for one cycle, busy=0 from the next cycle, go to IDLE.
  - Back-to-back: a start coincident with FINISH is ignored; it must arrive while in IDLE.
- Timing from start edge (cycle 0):
  - init high from cycle 1.
  - If com is seen at cycle k, rd_en[0] rises at cycle k+1.
  - done pulses at cycle k+1+DEPTH+LANES-1.
- Widths: counters are sized to hold max(LOAD_TIMEOUT, DEPTH+LANES) without wrap. rd_en is never wider than LANES.
- com seen high in IDLE, STREAM or FINISH has no effect.

Optional Feature:
- Macro FEED_STALL_EN.
- Defined:
  - Adds input port stall (1 bit).
  - While stall=1 in STREAM: step counter holds and rd_en=0 for that cycle.
  - The wavefront resumes at the same t when stall=0, so each lane still gets exactly DEPTH read cycles and the relative skew is preserved.
  - stall is ignored outside STREAM.
- Undefined: no stall port; STREAM always advances one step per cycle.

Test Plan:
- Reset: hold rst=0 for 2 edges with start=1 → all outputs 0, state IDLE, no init.
- Nominal run: base_in=8'h20 with start pulse, com after 12 cycles in LOAD → base_address=8'h20, init high for 12 cycles then low. Then rd_en goes 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000, followed by a single done pulse.
- Timeout (LOAD_TIMEOUT=20): start, com held 0 → init drops after 20 LOAD cycles, err=1, no done, rd_en stays 0. A following start clears err.
- Reset mid-STREAM: at step t=3, drive rst=0 → next edge has rd_en=0, busy=0, no done pulse. A new start restarts from LOAD.
- Ignored requests: start pulses during LOAD and STREAM, plus com pulses in IDLE → run timing is unchanged, no extra init.
- FEED_STALL_EN: stall=1 for 2 cycles at t=2 → rd_en=0 during the stall, pattern resumes at 00111. Each lane totals 5 read cycles and done is delayed by 2 cycles.

Source files
------------

// File: rtl/systolic_feed_ctrl.sv
// Sequencer for MEM_FIFO: loads memory into the lane FIFOs, then issues skewed read enables.
// Latency: init 1 cycle after start; rd_en[0] 1 cycle after com; done DEPTH+LANES-1 cycles later.
// Backpressure: optional FEED_STALL_EN macro adds a stall input that freezes the wavefront in STREAM.
module systolic_feed_ctrl #(
  parameter int LANES        = 5,
  parameter int DEPTH        = 5,
  parameter int ADDR_W       = 8,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_in,
  input  logic              com,
`ifdef FEED_STALL_EN
  input  logic              stall,
`endif
  output logic              init,
  output logic [ADDR_W-1:0] base_address,
  output logic [LANES-1:0]  rd_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One counter serves both the load timeout and the stream step, so it is
  // sized for whichever of the two needs more range.
  localparam int CNT_MAX = (LOAD_TIMEOUT > DEPTH + LANES) ? LOAD_TIMEOUT : DEPTH + LANES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(DEPTH + LANES - 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             stream_hold;

`ifdef FEED_STALL_EN
  assign stream_hold = stall;
`else
  assign stream_hold = 1'b0;
`endif

  // Lane i reads while i <= t < i+DEPTH, giving the diagonal wavefront.
  function automatic logic [LANES-1:0] wave(input logic [CNT_W-1:0] t);
    logic [LANES-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      v[i] = (CNT_W'(i) <= t) && (t < CNT_W'(i + DEPTH));
    end
    return v;
  endfunction

  // Control FSM; every output is a register so MEM_FIFO sees glitch-free enables.
  // In STREAM, cnt holds the step currently driven on rd_en.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      init         <= 1'b0;
      base_address <= '0;
      rd_en        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_LOAD;
            base_address <= base_in;
            err          <= 1'b0;
            cnt          <= '0;
            init         <= 1'b1;
            busy         <= 1'b1;
          end
        end
        S_LOAD: begin
          // com takes priority over a timeout landing on the same cycle.
          if (com) begin
            state <= S_STREAM;
            init  <= 1'b0;
            cnt   <= '0;
            rd_en <= wave('0);
          end else if (cnt == LOAD_LAST) begin
            state <= S_IDLE;
            init  <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_STREAM: begin
          // A stall blanks the enables but keeps the step, so the skew survives.
          if (stream_hold) begin
            rd_en <= '0;
          end else if (cnt == STEP_LAST) begin
            state <= S_FINISH;
            rd_en <= '0;
            done  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + CNT_W'(1);
            rd_en <= wave(cnt + CNT_W'(1));
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          init  <= 1'b0;
          rd_en <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: directed runs with literal checks plus a
// timeline model compared against the outputs every cycle.
module tb_systolic_feed_ctrl;

  localparam int LANES = 5;
  localparam int DEPTH = 5;
  localparam int AW    = 8;
  localparam int TMO   = 20;
  localparam int STEPS = DEPTH + LANES - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW-1:0]    base_in;
  logic             com;
  logic             stall;
  logic             init;
  logic [AW-1:0]    base_address;
  logic [LANES-1:0] rd_en;
  logic             busy;
  logic             done;
  logic             err;

  int n_cmp = 0;
  int n_bad = 0;

  systolic_feed_ctrl #(
    .LANES(LANES), .DEPTH(DEPTH), .ADDR_W(AW), .LOAD_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_in(base_in), .com(com),
`ifdef FEED_STALL_EN
    .stall(stall),
`endif
    .init(init), .base_address(base_address), .rd_en(rd_en),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act_v, exp_v, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- timeline model ----------------
  // A run is described by when start was accepted, when com was accepted and
  // how many stream cycles were stalled; outputs follow from those timestamps.
  int   n       = 0;
  bit   act     = 0;
  int   t_start = 0;
  int   t_com   = -1;
  int   stalls  = 0;
  bit   stall_now;
  bit   m_valid = 0;
  bit   m_err   = 0;
  logic [AW-1:0]    m_base = '0;
  logic             e_init, e_busy, e_done;
  logic [LANES-1:0] e_rd;

  always @(posedge clk) begin
    int p;
    n = n + 1;
    stall_now = 0;
    if (!rst) begin
      act = 0; m_err = 0; m_base = '0; t_com = -1; stalls = 0; m_valid = 1;
    end else if (!act) begin
      if (start) begin
        act = 1; m_base = base_in; m_err = 0; t_start = n; t_com = -1; stalls = 0;
      end
    end else if (t_com < 0) begin
      if (com) t_com = n;
      else if (n - t_start == TMO) begin
        act = 0; m_err = 1;
      end
    end else begin
      if ((n - t_com - stalls) <= STEPS && stall === 1'b1) begin
        stalls++; stall_now = 1;
      end
      if (n - t_com - stalls == STEPS + 1) act = 0;
    end
    p      = n - t_com - stalls;
    e_init = act && (t_com < 0);
    e_busy = act;
    e_done = act && (t_com >= 0) && (p == STEPS) && !stall_now;
    e_rd   = '0;
    if (act && t_com >= 0 && !stall_now && p < STEPS)
      for (int i = 0; i < LANES; i++) e_rd[i] = (i <= p) && (p < i + DEPTH);
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_init", init, e_init);
      chk("cyc_busy", busy, e_busy);
      chk("cyc_done", done, e_done);
      chk("cyc_err", err, m_err);
      chk("cyc_rd_en", rd_en, e_rd);
      chk("cyc_base", base_address, m_base);
    end
  end

  // ---------------- directed stimulus ----------------
  logic [LANES-1:0] wave_lit [9] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111,
                                     5'b11110, 5'b11100, 5'b11000, 5'b10000};

  initial begin
    int icnt;
    int dcnt;
    int dcyc;
    int lane_sum [LANES];

    rst = 1'b0; start = 1'b1; base_in = 8'hAA; com = 1'b1; stall = 1'b0;
    tick; tick;
    chk("rst_init", init, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_base", base_address, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b1; start = 1'b0; com = 1'b0;
    tick; tick;

    // Nominal run: com seen after 12 LOAD cycles.
    base_in = 8'h20; start = 1'b1; tick; start = 1'b0; base_in = 8'h77;
    chk("nom_base", base_address, 8'h20);
    chk("nom_busy", busy, 1);
    icnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (init) icnt++;
      if (c == 11) com = 1'b1;
      tick;
    end
    com = 1'b0;
    chk("nom_init_cycles", icnt, 12);
    chk("nom_init_low", init, 0);
    for (int s = 0; s < 9; s++) begin
      chk("nom_wave", rd_en, wave_lit[s]);
      chk("nom_no_early_done", done, 0);
      tick;
    end
    chk("nom_done", done, 1);
    chk("nom_rd_off", rd_en, 0);
    tick;
    chk("nom_done_pulse", done, 0);
    chk("nom_idle", busy, 0);
    tick;

    // Load timeout, then a new start clears err.
    start = 1'b1; tick; start = 1'b0;
    icnt = 0;
    for (int c = 0; c < TMO; c++) begin
      if (init) icnt++;
      tick;
    end
    chk("tmo_init_cycles", icnt, 20);
    chk("tmo_init_low", init, 0);
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    dcnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (done || rd_en != 0) dcnt++;
      tick;
    end
    chk("tmo_no_done", dcnt, 0);
    chk("tmo_err_sticky", err, 1);
    start = 1'b1; tick; start = 1'b0;
    chk("tmo_err_clear", err, 0);
    chk("tmo_restart_init", init, 1);

    // Reset in the middle of STREAM.
    tick; tick;
    com = 1'b1; tick; com = 1'b0;
    tick; tick; tick;
    chk("mid_t3", rd_en, 5'b01111);
    rst = 1'b0; tick; rst = 1'b1;
    chk("mid_rd_off", rd_en, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    tick;
    chk("mid_no_done", done, 0);
    base_in = 8'h3C; start = 1'b1; tick; start = 1'b0;
    chk("mid_reload", init, 1);
    chk("mid_base", base_address, 8'h3C);
    tick;
    com = 1'b1; tick; com = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) dcnt++;
      tick;
    end
    chk("mid_done_count", dcnt, 1);

    // Ignored requests: com in IDLE, start in LOAD, STREAM and FINISH.
    com = 1'b1; tick; tick; com = 1'b0;
    chk("ign_idle_com", busy, 0);
    base_in = 8'h42; start = 1'b1; tick; start = 1'b0;
    tick;
    base_in = 8'h99; start = 1'b1; tick; start = 1'b0;
    chk("ign_load_base", base_address, 8'h42);
    tick;
    com = 1'b1; tick; com = 1'b0;
    chk("ign_wave0", rd_en, 5'b00001);
    tick; tick;
    start = 1'b1; tick; start = 1'b0;
    chk("ign_stream_rd", rd_en, 5'b01111);
    for (int c = 0; c < 5; c++) tick;
    chk("ign_last_step", rd_en, 5'b10000);
    tick;
    chk("ign_done", done, 1);
    start = 1'b1; tick; start = 1'b0;
    chk("ign_finish_start_busy", busy, 0);
    tick;
    chk("ign_finish_start_init", init, 0);
    tick;

`ifdef FEED_STALL_EN
    // Two-cycle stall at t=2.
    start = 1'b1; tick; start = 1'b0;
    com = 1'b1; tick; com = 1'b0;
    for (int i = 0; i < LANES; i++) lane_sum[i] = 0;
    dcyc = -1;
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < LANES; i++) lane_sum[i] += int'(rd_en[i]);
      if (done) dcyc = c;
      if (c == 2 || c == 3) chk("stall_blank", rd_en, 0);
      if (c == 4) chk("stall_resume", rd_en, 5'b00111);
      stall = (c == 1 || c == 2);
      tick;
    end
    stall = 1'b0;
    for (int i = 0; i < LANES; i++) chk("stall_lane_total", lane_sum[i], DEPTH);
    chk("stall_done_cycle", dcyc, 11);
`else
    lane_sum[0] = 0;
    dcyc = 0;
`endif

    tick; tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
